// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 32-bit instruction words from instruction memory,
// holds each one on `instruction` until the controller retires it with `dne`,
// then advances pc sequentially or to a jump target.
//
// Ports:
//   clk, reset            clock; async active-low reset
//   mem_req, mem_addr     fetch request/address to instruction memory
//   mem_ack, mem_rdata    memory response (data valid when mem_ack=1)
//   instruction           instruction register to the controller
//   instr_valid           instruction holds a fetched, not yet retired word
//   dne, jumping          retire pulse; take jump_target on this retire
//   jump_target           next pc when jumping
//   pc                    architectural pc
//   fetch_count           completed fetches (wraps)
//   fstate                FSM state: IDLE=0, FETCH=1, ISSUE=2
module instr_fetch_unit #(
  parameter int unsigned                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]          RESET_PC = '0,
  parameter logic [ADDR_W-1:0]          PC_STEP  = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              dne,
  input  logic              jumping,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       fetch_count,
  output logic [1:0]        fstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   fill;    // ack accepted this edge
  logic   retire;  // dne accepted this edge

  // Next-state: mem_ack only counts in FETCH, dne/jumping only in ISSUE.
  always_comb begin
    state_nx = state;
    fill     = 1'b0;
    retire   = 1'b0;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: if (mem_ack) begin
               fill     = 1'b1;
               state_nx = ISSUE;
             end
      ISSUE: if (dne) begin
               retire   = 1'b1;
               state_nx = FETCH;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath. mem_req is raised on every entry to FETCH and dropped on fill,
  // so it is a registered, glitch-free request that holds through wait states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      if (state == IDLE) mem_req <= 1'b1;
      if (fill) begin
        instruction <= mem_rdata;
        instr_valid <= 1'b1;
        mem_req     <= 1'b0;
        fetch_count <= fetch_count + 16'd1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        mem_req     <= 1'b1;
        pc          <= jumping ? jump_target : pc + PC_STEP;  // wraps mod 2^ADDR_W
      end
    end
  end

  // pc only changes on retire, i.e. while not fetching, so it doubles as the
  // stable fetch address.
  assign mem_addr = pc;
  assign fstate   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        dne = 1'b0;
  logic        jumping = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] pc;
  logic [15:0] fetch_count;
  logic [1:0]  fstate;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t exp_q[$];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .dne(dne), .jumping(jumping), .jump_target(jump_target),
    .pc(pc), .fetch_count(fetch_count), .fstate(fstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:        return 32'h08220000;
      32'h1:        return 32'h28B10000;
      32'h2:        return 32'h01C80000;
      32'h40:       return 32'h0FFE0000;
      32'hFFFFFFFF: return 32'h12345678;
      default:      return 32'hDEAD0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  // Memory responder: wait_n idle cycles before ack; ack_always floods acks
  // with junk data while no request is pending.
  int wait_n = 0;
  int wcnt = 0;
  bit ack_always = 0;
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt = 0; mem_ack = ack_always; mem_rdata = 32'hBAD0BAD0;
    end else if (wcnt >= wait_n) begin
      mem_ack = 1'b1; mem_rdata = memf(mem_addr);
    end else begin
      wcnt++; mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
    end
  end

  // Scoreboard monitor: every new issue is checked against the queue.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset && instr_valid && !prev_v) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 32'h1, 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_instr", instruction, e.ins);
        chk("issue_pc", pc, e.pc);
      end
    end
    prev_v = instr_valid;
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 30) begin @(negedge clk); n++; end
    if (!instr_valid) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_dne(input logic j, input logic [31:0] tgt, input logic [31:0] exp_pc);
    @(negedge clk);
    dne = 1'b1; jumping = j; jump_target = tgt;
    @(posedge clk); #1;
    dne = 1'b0; jumping = 1'b0;
    chk("retire_pc", pc, exp_pc);
    chk("retire_mem_addr", mem_addr, exp_pc);
    chk("retire_mem_req", {31'h0, mem_req}, 32'h1);
    chk("retire_valid", {31'h0, instr_valid}, 32'h0);
    chk("retire_fstate", {30'h0, fstate}, 32'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_fcount"}, {16'h0, fetch_count}, 32'h0);
    chk({tag, "_fstate"}, {30'h0, fstate}, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    // Sequential run
    exp_q.push_back('{32'h0, 32'h08220000});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("e1_fstate", {30'h0, fstate}, 32'h1);
    chk("e1_mem_req", {31'h0, mem_req}, 32'h1);
    chk("e1_valid", {31'h0, instr_valid}, 32'h0);
    @(posedge clk); #1;
    chk("e2_valid", {31'h0, instr_valid}, 32'h1);
    chk("e2_instr", instruction, 32'h08220000);
    exp_q.push_back('{32'h1, 32'h28B10000});
    pulse_dne(1'b0, 32'h0, 32'h1);
    wait_valid();
    exp_q.push_back('{32'h2, 32'h01C80000});
    pulse_dne(1'b0, 32'h0, 32'h2);
    wait_valid();
    chk("seq_fcount", {16'h0, fetch_count}, 32'd3);

    // mem_ack in ISSUE ignored
    ack_always = 1;
    repeat (3) @(posedge clk); #1;
    chk("ack_issue_instr", instruction, 32'h01C80000);
    chk("ack_issue_fstate", {30'h0, fstate}, 32'h2);
    chk("ack_issue_fcount", {16'h0, fetch_count}, 32'd3);
    ack_always = 0;

    // jumping without dne ignored
    @(negedge clk); jumping = 1'b1; jump_target = 32'h99;
    repeat (2) @(posedge clk); #1;
    chk("jmp_nodne_pc", pc, 32'h2);
    chk("jmp_nodne_fstate", {30'h0, fstate}, 32'h2);
    jumping = 1'b0;

    // Jump with 3 wait states; dne pulsed during FETCH is ignored
    wait_n = 3;
    exp_q.push_back('{32'h40, 32'h0FFE0000});
    pulse_dne(1'b1, 32'h40, 32'h40);
    @(negedge clk); dne = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dne = 1'b0;
      chk("wait_mem_req", {31'h0, mem_req}, 32'h1);
      chk("wait_mem_addr", mem_addr, 32'h40);
      chk("wait_instr", instruction, 32'h01C80000);
      chk("wait_fcount", {16'h0, fetch_count}, 32'd3);
      chk("wait_fstate", {30'h0, fstate}, 32'h1);
    end
    @(posedge clk); #1;
    chk("ack_fcount", {16'h0, fetch_count}, 32'd4);
    chk("ack_instr", instruction, 32'h0FFE0000);
    chk("ack_pc", pc, 32'h40);
    wait_n = 0;

    // PC wrap
    wait_valid();
    exp_q.push_back('{32'hFFFFFFFF, 32'h12345678});
    pulse_dne(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid();
    exp_q.push_back('{32'h0, 32'h08220000});
    pulse_dne(1'b0, 32'h0, 32'h0);
    wait_valid();
    chk("wrap_fcount", {16'h0, fetch_count}, 32'd6);

    // Reset mid-fetch, between edges
    wait_n = 3;
    pulse_dne(1'b0, 32'h0, 32'h1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midreset");
    wait_n = 0;
    @(negedge clk);
    exp_q.push_back('{32'h0, 32'h08220000});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart_fstate", {30'h0, fstate}, 32'h1);
    chk("restart_pc", pc, 32'h0);
    chk("restart_fcount", {16'h0, fetch_count}, 32'h0);
    chk("restart_mem_req", {31'h0, mem_req}, 32'h1);
    wait_valid();
    @(negedge clk);
    chk("restart_fcount_after", {16'h0, fetch_count}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
